// File: rtl/rx_ctrl_pkg.sv
// Shared types and constants for the receive-side frame sequencer.
// Optional feature macro used by the design: RX_TIMEOUT_EN.
package rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HUNT    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    DRAIN   = 3'd4
  } rx_state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_ZERO_LEN = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam int         SYNC_W_DEF      = 8;
  localparam logic [7:0] SYNC_WORD_DEF   = 8'hA5;
  localparam int         CW_W_DEF        = 7;
  localparam int         LEN_W_DEF       = 4;
  localparam int         TIMEOUT_CYC_DEF = 1024;

endpackage

// File: rtl/rx_bit_shifter.sv
// MSB-first serial-to-parallel shift register with a saturating fill count.
// Only the N-1 most recent bits are stored; word_o assembles the full N-bit
// word including the bit currently presented, so the caller can act on the
// same strobe that delivers the last bit. full_o is high when that word holds
// at least N collected bits. Clear has priority over shift.
module rx_bit_shifter #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic         bit_i,
  output logic [N-1:0] word_o,
  output logic         full_o
);

  localparam int CNT_W = $clog2(N + 1);

  logic [N-2:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: clear, or shift one bit in at the LSB and count it (saturating)
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      data_d = {data_q[N-3:0], bit_i};
      if (cnt_q != CNT_W'(N)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Register the stored bits and the fill count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o = {data_q, bit_i};
  assign full_o = (cnt_q >= CNT_W'(N - 1));

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive-side frame sequencer: sync hunt, length field, codeword deserialiser
// and a one-entry holding buffer towards the Hamming decoder.
// Optional feature macro: RX_TIMEOUT_EN (inactivity timeout in LEN/PAYLOAD/DRAIN).
// Handshake: cw_data/cw_valid come from a holding register; once cw_valid is
// high, cw_data stays stable until a cycle with cw_valid && cw_ready, which is
// the single transfer point. cw_valid never depends combinationally on cw_ready.
module rx_frame_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int               SYNC_W    = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int               CW_W      = CW_W_DEF,
  parameter int               LEN_W     = LEN_W_DEF
`ifdef RX_TIMEOUT_EN
  ,
  parameter int               TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [CW_W-1:0]  cw_data,
  output logic             cw_valid,
  input  logic             cw_ready,
  output logic [LEN_W-1:0] frame_len,
  output logic             busy,
  output logic             frame_start,
  output logic             frame_done,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output rx_state_e        dbg_state
);

  rx_state_e        state_q, state_d;
  logic [CW_W-1:0]  cw_data_q, cw_data_d;
  logic             cw_valid_q, cw_valid_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic [LEN_W-1:0] cw_cnt_q, cw_cnt_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic              sync_clr, len_clr, cw_clr;
  logic [SYNC_W-1:0] sync_word;
  logic [LEN_W-1:0]  len_word;
  logic [CW_W-1:0]   cw_word;
  logic              sync_full, len_full, cw_full;

`ifdef RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  rx_bit_shifter #(.N(SYNC_W)) u_sync_shift (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (sync_clr),
    .shift_i (bit_valid && (state_q == HUNT || state_q == DRAIN)),
    .bit_i   (bit_in),
    .word_o  (sync_word),
    .full_o  (sync_full)
  );

  rx_bit_shifter #(.N(LEN_W)) u_len_shift (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (len_clr),
    .shift_i (bit_valid && state_q == LEN),
    .bit_i   (bit_in),
    .word_o  (len_word),
    .full_o  (len_full)
  );

  rx_bit_shifter #(.N(CW_W)) u_cw_shift (
    .clock   (clock),
    .reset   (reset),
    .clr_i   (cw_clr),
    .shift_i (bit_valid && state_q == PAYLOAD),
    .bit_i   (bit_in),
    .word_o  (cw_word),
    .full_o  (cw_full)
  );

  // Next-state, buffer and pulse logic; enable=0 overrides everything last
  always_comb begin
    state_d     = state_q;
    cw_data_d   = cw_data_q;
    cw_valid_d  = cw_valid_q;
    frame_len_d = frame_len_q;
    cw_cnt_d    = cw_cnt_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    sync_clr    = 1'b0;
    len_clr     = 1'b0;
    cw_clr      = 1'b0;
`ifdef RX_TIMEOUT_EN
    tmo_d       = '0;
`endif

    // A transfer empties the buffer unless a new codeword refills it below
    if (cw_valid_q && cw_ready) begin
      cw_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = HUNT;
          sync_clr = 1'b1;
        end
      end
      HUNT: begin
        if (bit_valid && sync_full && sync_word == SYNC_WORD) begin
          state_d    = LEN;
          start_d    = 1'b1;
          err_code_d = ERR_NONE;
          len_clr    = 1'b1;
        end
      end
      LEN: begin
        if (bit_valid && len_full) begin
          frame_len_d = len_word;
          if (len_word == '0) begin
            err_d      = 1'b1;
            err_code_d = ERR_ZERO_LEN;
            state_d    = HUNT;
            sync_clr   = 1'b1;
          end else begin
            state_d  = PAYLOAD;
            cw_cnt_d = '0;
            cw_clr   = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (bit_valid && cw_full) begin
          cw_clr = 1'b1;
          if (cw_valid_q && !cw_ready) begin
            // Buffer still occupied: keep the old codeword, drop the new one
            err_d      = 1'b1;
            err_code_d = ERR_OVERFLOW;
            state_d    = HUNT;
            sync_clr   = 1'b1;
          end else begin
            cw_data_d  = cw_word;
            cw_valid_d = 1'b1;
            cw_cnt_d   = cw_cnt_q + 1'b1;
            if (cw_cnt_q == frame_len_q - 1'b1) begin
              state_d  = DRAIN;
              sync_clr = 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        if (cw_valid_q && cw_ready) begin
          done_d  = 1'b1;
          state_d = HUNT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef RX_TIMEOUT_EN
    // Inactivity timer: counts only while nothing moves in an active frame
    if ((state_q == LEN || state_q == PAYLOAD || state_q == DRAIN) &&
        state_d == state_q && !bit_valid && !(state_q == DRAIN && cw_ready)) begin
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        err_d      = 1'b1;
        err_code_d = ERR_TIMEOUT;
        state_d    = HUNT;
        sync_clr   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    if (!enable) begin
      state_d     = IDLE;
      cw_valid_d  = 1'b0;
      cw_data_d   = cw_data_q;
      frame_len_d = frame_len_q;
      cw_cnt_d    = cw_cnt_q;
      start_d     = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      sync_clr    = 1'b0;
      len_clr     = 1'b0;
      cw_clr      = 1'b0;
`ifdef RX_TIMEOUT_EN
      tmo_d       = '0;
`endif
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cw_data_q   <= '0;
      cw_valid_q  <= 1'b0;
      frame_len_q <= '0;
      cw_cnt_q    <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cw_data_q   <= cw_data_d;
      cw_valid_q  <= cw_valid_d;
      frame_len_q <= frame_len_d;
      cw_cnt_q    <= cw_cnt_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

`ifdef RX_TIMEOUT_EN
  // Inactivity timer register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign cw_data     = cw_data_q;
  assign cw_valid    = cw_valid_q;
  assign frame_len   = frame_len_q;
  assign busy        = (state_q == LEN) || (state_q == PAYLOAD);
  assign frame_start = start_q;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign err_code    = err_code_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl with a codeword scoreboard.
// Honours RX_TIMEOUT_EN the same way the design does.
module tb_rx_frame_ctrl;
  import rx_ctrl_pkg::*;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       bit_valid;
  logic       bit_in;
  logic [6:0] cw_data;
  logic       cw_valid;
  logic       cw_ready;
  logic [3:0] frame_len;
  logic       busy;
  logic       frame_start;
  logic       frame_done;
  logic       frame_err;
  logic [1:0] err_code;
  rx_state_e  dbg_state;

  int total = 0;
  int bad   = 0;
  int n_start = 0, n_done = 0, n_err = 0;
  int exp_start = 0, exp_done = 0, exp_err = 0;
  logic [6:0] exp_q[$];

  rx_frame_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .cw_data     (cw_data),
    .cw_valid    (cw_valid),
    .cw_ready    (cw_ready),
    .frame_len   (frame_len),
    .busy        (busy),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe mid-cycle (handshake, pulses), then step past the edge
  task automatic tick();
    logic [6:0] e;
    @(negedge clock);
    check("pulse_onehot", {31'd0, ($countones({frame_start, frame_done, frame_err}) <= 1)}, 32'd1);
    if (frame_start) n_start++;
    if (frame_done)  n_done++;
    if (frame_err)   n_err++;
    if (cw_valid && cw_ready) begin
      if (exp_q.size() == 0) begin
        check("cw_unexpected", {25'd0, cw_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("cw_data", {25'd0, cw_data}, {25'd0, e});
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  // MSB-first with 0..2 idle cycles before each bit
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      repeat ($urandom_range(0, 2)) tick();
      send_bit(v[i]);
    end
  endtask

  task automatic send_sync();
    send_bits(32'hA5, 8);
    exp_start++;
    check("sync_start", {31'd0, frame_start}, 32'd1);
    check("sync_errcode", {30'd0, err_code}, ERR_NONE);
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    cw_ready  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_cw_valid", {31'd0, cw_valid}, 32'd0);
    check("rst_cw_data", {25'd0, cw_data}, 32'd0);
    check("rst_frame_len", {28'd0, frame_len}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_pulses", {29'd0, frame_start, frame_done, frame_err}, 32'd0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b1;
    tick();
    enable = 1'b1;
    tick();
    check("enter_hunt", dbg_state, HUNT);

    // Nominal frame, ready tied high
    cw_ready = 1'b1;
    send_sync();
    check("nom_state_len", dbg_state, LEN);
    check("nom_busy", {31'd0, busy}, 32'd1);
    send_bits(32'h2, 4);
    check("nom_state_payload", dbg_state, PAYLOAD);
    check("nom_frame_len", {28'd0, frame_len}, 32'd2);
    exp_q.push_back(7'h55);
    send_bits(32'h55, 7);
    check("nom_cw1_valid", {31'd0, cw_valid}, 32'd1);
    check("nom_cw1_data", {25'd0, cw_data}, 32'h55);
    tick();
    check("nom_cw1_one_cycle", {31'd0, cw_valid}, 32'd0);
    exp_q.push_back(7'h2A);
    send_bits(32'h2A, 7);
    check("nom_cw2_valid", {31'd0, cw_valid}, 32'd1);
    check("nom_drain", dbg_state, DRAIN);
    tick();
    exp_done++;
    check("nom_done", {31'd0, frame_done}, 32'd1);
    check("nom_back_hunt", dbg_state, HUNT);
    check("nom_err_code", {30'd0, err_code}, ERR_NONE);

    // Sync embedded in noise: 0xFA5
    send_bits(32'h7D2, 11);
    check("noise_no_early_start", {31'd0, frame_start}, 32'd0);
    check("noise_still_hunt", dbg_state, HUNT);
    send_bit(1'b1);
    exp_start++;
    check("noise_start", {31'd0, frame_start}, 32'd1);
    send_bits(32'h1, 4);
    exp_q.push_back(7'h33);
    send_bits(32'h33, 7);
    tick();
    exp_done++;
    check("noise_done", {31'd0, frame_done}, 32'd1);

    // Zero length, then a normal frame
    send_sync();
    send_bits(32'h0, 4);
    exp_err++;
    check("zlen_err", {31'd0, frame_err}, 32'd1);
    check("zlen_code", {30'd0, err_code}, ERR_ZERO_LEN);
    check("zlen_hunt", dbg_state, HUNT);
    send_sync();
    send_bits(32'h1, 4);
    exp_q.push_back(7'h0F);
    send_bits(32'h0F, 7);
    tick();
    exp_done++;
    check("zlen_next_done", {31'd0, frame_done}, 32'd1);

    // Overflow: decoder never ready
    cw_ready = 1'b0;
    send_sync();
    send_bits(32'h3, 4);
    exp_q.push_back(7'h11);
    send_bits(32'h11, 7);
    repeat (3) tick();
    check("ovf_held_valid", {31'd0, cw_valid}, 32'd1);
    check("ovf_held_data", {25'd0, cw_data}, 32'h11);
    send_bits(32'h22, 7);
    exp_err++;
    check("ovf_err", {31'd0, frame_err}, 32'd1);
    check("ovf_code", {30'd0, err_code}, ERR_OVERFLOW);
    check("ovf_keep_data", {25'd0, cw_data}, 32'h11);
    check("ovf_keep_valid", {31'd0, cw_valid}, 32'd1);
    check("ovf_hunt", dbg_state, HUNT);
    cw_ready = 1'b1;
    tick();
    check("ovf_drained", {31'd0, cw_valid}, 32'd0);
    enable = 1'b0;
    tick();
    check("dis_idle", dbg_state, IDLE);
    check("dis_code_held", {30'd0, err_code}, ERR_OVERFLOW);
    enable = 1'b1;
    tick();

    // Backpressure boundary: ready rises on the completing bit of codeword 2
    cw_ready = 1'b0;
    send_sync();
    send_bits(32'h2, 4);
    exp_q.push_back(7'h44);
    send_bits(32'h44, 7);
    exp_q.push_back(7'h3B);
    send_bits(32'h1D, 6);
    cw_ready = 1'b1;
    send_bit(1'b1);
    check("bp_no_err", {31'd0, frame_err}, 32'd0);
    check("bp_valid", {31'd0, cw_valid}, 32'd1);
    check("bp_data", {25'd0, cw_data}, 32'h3B);
    check("bp_drain", dbg_state, DRAIN);
    tick();
    exp_done++;
    check("bp_done", {31'd0, frame_done}, 32'd1);

    // Enable dropped mid-payload with a codeword buffered
    cw_ready = 1'b0;
    send_sync();
    send_bits(32'h2, 4);
    send_bits(32'h19, 7);
    send_bits(32'h7, 3);
    check("abort_pre_valid", {31'd0, cw_valid}, 32'd1);
    enable = 1'b0;
    tick();
    check("abort_idle", dbg_state, IDLE);
    check("abort_valid", {31'd0, cw_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_err", {31'd0, frame_err}, 32'd0);
    check("abort_len_held", {28'd0, frame_len}, 32'd2);
    enable   = 1'b1;
    cw_ready = 1'b1;
    tick();
    check("abort_rehunt", dbg_state, HUNT);

    // Bit stream stalls inside the length field
    send_sync();
    send_bits(32'h1, 2);
`ifdef RX_TIMEOUT_EN
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 1100 && !seen; i++) begin
        tick();
        if (frame_err) seen = 1'b1;
      end
      exp_err++;
      check("tmo_err_seen", {31'd0, seen}, 32'd1);
      check("tmo_code", {30'd0, err_code}, ERR_TIMEOUT);
      check("tmo_hunt", dbg_state, HUNT);
    end
`else
    repeat (1100) tick();
    check("notmo_still_len", dbg_state, LEN);
    check("notmo_code", {30'd0, err_code}, ERR_NONE);
`endif

    repeat (3) tick();
    check("cnt_start", n_start, exp_start);
    check("cnt_done", n_done, exp_done);
    check("cnt_err", n_err, exp_err);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Receive-side sequencer for the FSK/Hamming link. Sits between the FSK demodulator's bit strobe and the Hamming(7,4) decoder.
- Hunts for a sync word, reads a 4-bit codeword-count field, then deserializes that many 7-bit codewords MSB-first.
- Hands each codeword to the decoder over a valid/ready handshake and reports frame start, completion and errors.

Parameters:
- SYNC_W, 8, sync word width in bits.
- SYNC_WORD, 8'hA5, sync pattern, compared MSB-first.
- CW_W, 7, codeword width (Hamming 7,4).
- LEN_W, 4, width of the codeword-count field.
- TIMEOUT_CYC, 1024, clock cycles without bit_valid before a frame aborts (optional feature only).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  receiver enable; low means synchronous abort to IDLE
- bit_valid  in  1  one-cycle strobe from the demodulator; bit_in is sampled only when this is high
- bit_in  in  1  demodulated bit
- cw_data  out  CW_W  codeword to the decoder, MSB = first bit received
- cw_valid  out  1  cw_data is valid
- cw_ready  in  1  decoder accepts the codeword
- frame_len  out  LEN_W  count field of the current frame
- busy  out  1  high in states LEN and PAYLOAD
- frame_start  out  1  one-cycle pulse on sync detect
- frame_done  out  1  one-cycle pulse after the last codeword is accepted
- frame_err  out  1  one-cycle pulse on any abort
- err_code  out  2  cause of the last error, held until the next frame_start: 0 none, 1 zero length, 2 overflow, 3 timeout

Behaviour:
- Reset (asynchronous, active-low) drives all outputs, counters and shift registers to 0 and the state to IDLE.
- States: IDLE, HUNT, LEN, PAYLOAD, DRAIN.
- Only bit_valid cycles advance the shift register and the bit counters. bit_in is ignored on all other cycles.
- IDLE: when enable=1, go to HUNT the next cycle and clear the sync window and its fill counter.
- HUNT:
  - Shift bit_in into an SYNC_W-bit window (new bit into the LSB).
  - On the bit_valid where the window, including the new bit, equals SYNC_WORD and at least SYNC_W bits have been collected since entering HUNT:
    - pulse frame_start the next cycle;
    - set err_code to 0;
    - go to LEN.
  - Overlapping patterns are allowed; there is no minimum gap.
- LEN:
  - Collect LEN_W bits MSB-first into frame_len.
  - If the value is 0: pulse frame_err, set err_code=1, go to HUNT.
  - Otherwise go to PAYLOAD with the codeword counter set to 0.
- PAYLOAD:
  - Collect CW_W bits per codeword.
  - On the bit_valid that carries the last bit of a codeword, the codeword is complete. One cycle later, cw_data is loaded and cw_valid=1.
  - Holding buffer:
    - cw_valid stays high and cw_data stays stable until cw_valid && cw_ready.
    - If a codeword completes while the buffer is still full and cw_ready=0 in that same cycle, this is an overflow. The new codeword is dropped, the buffered one is kept, frame_err pulses, err_code=2, and the state goes to HUNT.
    - If cw_ready=1 in the completing cycle, the old codeword is accepted and the new one loads next cycle with no error.
  - After the frame_len-th codeword is loaded, go to DRAIN.
- DRAIN:
  - Wait for the handshake on the final codeword. frame_done pulses the cycle after that handshake, and the state goes to HUNT.
  - Bits arriving during DRAIN are shifted into a freshly cleared sync window, so back-to-back frames are caught.
- enable=0 in any state:
  - next cycle: state IDLE, cw_valid=0, busy=0;
  - no frame_err pulse;
  - err_code and frame_len are held.
- Only one of frame_start, frame_done and frame_err is ever high in a given cycle.
- Arithmetic:
  - Bit counters are ceil(log2(width+1)) bits wide and never wrap.
  - The codeword counter is LEN_W bits wide and compared against frame_len.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined: a cycle counter runs in LEN, PAYLOAD and DRAIN.
  - It clears on every bit_valid and on every state change.
  - When it reaches TIMEOUT_CYC-1: frame_err pulses, err_code=3, the state goes to HUNT.
  - A codeword already in the buffer stays valid until accepted.
  - In DRAIN, the counter also clears on cw_ready.
- Undefined: no counter; err_code 3 is never produced; the block waits indefinitely.

Decomposition:
- Package rx_ctrl_pkg holds:
  - the state enum (IDLE, HUNT, LEN, PAYLOAD, DRAIN);
  - the err_code constants ERR_NONE, ERR_ZERO_LEN, ERR_OVERFLOW, ERR_TIMEOUT;
  - default SYNC_WORD, CW_W and LEN_W.
- One sub-module, rx_bit_shifter: a parameterised width-N MSB-first shift register with clear, shift-enable and a "full" count flag. It is instantiated for the sync window, the length field and the codeword.

Test Plan:
- Nominal frame. Stimulus: bits A5, len 4'h2, codewords 7'h55 then 7'h2A, cw_ready tied 1. Response: frame_start once; cw_valid for 1 cycle each with 7'h55 then 7'h2A; frame_done the cycle after the second handshake; err_code=0.
- Sync embedded in noise. Stimulus: bits 0xFA5 (12 bits) then a frame. Response: frame_start one cycle after the 12th bit_valid; no earlier detection.
- Zero length. Stimulus: A5 then len 4'h0. Response: frame_err pulse, err_code=1, back in HUNT; a following valid A5 frame is received normally.
- Overflow. Stimulus: len 4'h3, cw_ready=0 throughout. Response: the first codeword is held; when the second completes, frame_err pulses and err_code=2; cw_data still shows the first codeword.
- Backpressure boundary. Stimulus: cw_ready rises in exactly the cycle the second codeword completes. Response: no error; the second codeword is presented the next cycle.
- Abort and timeout.
  - Stimulus: enable dropped mid-PAYLOAD. Response: IDLE next cycle, cw_valid=0, no frame_err.
  - Stimulus (RX_TIMEOUT_EN defined): bit_valid stops in LEN for 1024 cycles. Response: frame_err pulses and err_code=3.
